// File: rtl/demux1_4_reg_if.sv
// ----------------------------------------------------------------------------
// demux1_4_reg_if
// Bundles the producer-side handshake and the four consumer-side channels of
// demux1_4_reg.
//   slave  modport : the demultiplexer (takes Din/Control/In_Valid/Ready_*,
//                    drives In_Ready/Out_*/Valid_*/Count_*)
//   master modport : the surrounding logic (producer + four consumers)
// Optional feature macro: DEMUX_STATS_EN adds the Count_* drain counters.
// ----------------------------------------------------------------------------
interface demux1_4_reg_if #(
    parameter int Demux_Width = 8
);
    logic [Demux_Width-1:0] Din;
    logic [1:0]             Control;
    logic                   In_Valid;
    logic                   In_Ready;

    logic [Demux_Width-1:0] Out_A, Out_B, Out_C, Out_D;
    logic                   Valid_A, Valid_B, Valid_C, Valid_D;
    logic                   Ready_A, Ready_B, Ready_C, Ready_D;

`ifdef DEMUX_STATS_EN
    logic [15:0]            Count_A, Count_B, Count_C, Count_D;

    modport slave (
        input  Din, Control, In_Valid, Ready_A, Ready_B, Ready_C, Ready_D,
        output In_Ready, Out_A, Out_B, Out_C, Out_D,
        output Valid_A, Valid_B, Valid_C, Valid_D,
        output Count_A, Count_B, Count_C, Count_D
    );

    modport master (
        output Din, Control, In_Valid, Ready_A, Ready_B, Ready_C, Ready_D,
        input  In_Ready, Out_A, Out_B, Out_C, Out_D,
        input  Valid_A, Valid_B, Valid_C, Valid_D,
        input  Count_A, Count_B, Count_C, Count_D
    );
`else
    modport slave (
        input  Din, Control, In_Valid, Ready_A, Ready_B, Ready_C, Ready_D,
        output In_Ready, Out_A, Out_B, Out_C, Out_D,
        output Valid_A, Valid_B, Valid_C, Valid_D
    );

    modport master (
        output Din, Control, In_Valid, Ready_A, Ready_B, Ready_C, Ready_D,
        input  In_Ready, Out_A, Out_B, Out_C, Out_D,
        input  Valid_A, Valid_B, Valid_C, Valid_D
    );
`endif

endinterface

// File: rtl/demux1_4_reg.sv
// ----------------------------------------------------------------------------
// demux1_4_reg
// Registered 1-to-4 demultiplexer. One word per cycle from a single producer
// is steered by Control (0->A, 1->B, 2->C, 3->D) into a single-entry output
// register per channel; each channel drains to its own consumer with a
// valid/ready handshake.
//   Clk   : rising-edge clock
//   Reset : asynchronous, active-high reset
//   bus   : demux1_4_reg_if.slave (Din, Control, In_Valid, In_Ready,
//           Out_*/Valid_*/Ready_* per channel, Count_* with stats)
// Optional feature macro: DEMUX_STATS_EN adds a 16-bit wrapping drained-word
// counter per channel.
// ----------------------------------------------------------------------------
module demux1_4_reg #(
    parameter int Demux_Width = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    demux1_4_reg_if.slave   bus
);

    logic [Demux_Width-1:0] data_q [4];
    logic [3:0]             full_q;
    logic [3:0]             ready;
    logic [3:0]             sel;
    logic [3:0]             load;
    logic [3:0]             drain;
    logic                   in_ready;

    always_comb begin
        ready = {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A};
        sel = '0;
        sel[bus.Control] = 1'b1;
    end

    // Selected channel can take a word if empty or draining this same edge.
    assign in_ready = !full_q[bus.Control] || ready[bus.Control];
    assign load     = sel & {4{bus.In_Valid & in_ready}};
    assign drain    = full_q & ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            full_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.Din;
                end
                // A load on the draining edge keeps the channel full.
                full_q[k] <= load[k] | (full_q[k] & ~drain[k]);
            end
        end
    end

    assign bus.In_Ready = in_ready;
    assign bus.Out_A    = data_q[0];
    assign bus.Out_B    = data_q[1];
    assign bus.Out_C    = data_q[2];
    assign bus.Out_D    = data_q[3];
    assign bus.Valid_A  = full_q[0];
    assign bus.Valid_B  = full_q[1];
    assign bus.Valid_C  = full_q[2];
    assign bus.Valid_D  = full_q[3];

`ifdef DEMUX_STATS_EN
    logic [15:0] count_q [4];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned k = 0; k < 4; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    count_q[k] <= count_q[k] + 16'd1;
                end
            end
        end
    end

    assign bus.Count_A = count_q[0];
    assign bus.Count_B = count_q[1];
    assign bus.Count_C = count_q[2];
    assign bus.Count_D = count_q[3];
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// ----------------------------------------------------------------------------
// tb_demux1_4_reg
// Self-checking bench for demux1_4_reg: a channel-level model tracks what each
// output register must hold, a negedge process compares the DUT against it
// every cycle, and directed vectors pin hand-computed values.
// Honours DEMUX_STATS_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_demux1_4_reg;

    logic clk;
    logic rst;

    demux1_4_reg_if #(.Demux_Width(8)) bus ();

    demux1_4_reg #(.Demux_Width(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- channel-level model ----------------
    logic [7:0]  m_data [4] = '{default: 8'h00};
    logic        m_full [4] = '{default: 1'b0};
    logic [15:0] m_cnt  [4] = '{default: 16'h0};

    function automatic logic m_ready(input int k);
        case (k)
            0: return bus.Ready_A;
            1: return bus.Ready_B;
            2: return bus.Ready_C;
            default: return bus.Ready_D;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_data[k] = 8'h00;
                m_full[k] = 1'b0;
                m_cnt[k]  = 16'h0;
            end
        end else begin
            int  c;
            bit  take;
            c    = int'(bus.Control);
            take = bus.In_Valid && (!m_full[c] || m_ready(c));
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && m_ready(k)) begin
                    m_full[k] = 1'b0;
                    m_cnt[k]  = m_cnt[k] + 16'd1;
                end
            end
            if (take) begin
                m_full[c] = 1'b1;
                m_data[c] = bus.Din;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int c;
        c = int'(bus.Control);
        check("in_ready", 32'(bus.In_Ready), 32'(!m_full[c] || m_ready(c)));
        check("valid_a", 32'(bus.Valid_A), 32'(m_full[0]));
        check("valid_b", 32'(bus.Valid_B), 32'(m_full[1]));
        check("valid_c", 32'(bus.Valid_C), 32'(m_full[2]));
        check("valid_d", 32'(bus.Valid_D), 32'(m_full[3]));
        check("out_a", 32'(bus.Out_A), 32'(m_data[0]));
        check("out_b", 32'(bus.Out_B), 32'(m_data[1]));
        check("out_c", 32'(bus.Out_C), 32'(m_data[2]));
        check("out_d", 32'(bus.Out_D), 32'(m_data[3]));
`ifdef DEMUX_STATS_EN
        check("count_a", 32'(bus.Count_A), 32'(m_cnt[0]));
        check("count_b", 32'(bus.Count_B), 32'(m_cnt[1]));
        check("count_c", 32'(bus.Count_C), 32'(m_cnt[2]));
        check("count_d", 32'(bus.Count_D), 32'(m_cnt[3]));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] d);
        bus.In_Valid = v;
        bus.Control  = c;
        bus.Din      = d;
    endtask

    task automatic set_ready(input logic [3:0] r);
        bus.Ready_A = r[0];
        bus.Ready_B = r[1];
        bus.Ready_C = r[2];
        bus.Ready_D = r[3];
    endtask

    logic [7:0] route_val [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00);
        set_ready(4'b0000);
        #2;
        check("rst_in_ready", 32'(bus.In_Ready), 32'd1);
        check("rst_valids", 32'({bus.Valid_D, bus.Valid_C, bus.Valid_B, bus.Valid_A}), 32'h0);
        check("rst_outs", {bus.Out_D, bus.Out_C, bus.Out_B, bus.Out_A}, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(bus.In_Ready), 32'd1);
        step();

        // Route one word to each channel on consecutive cycles.
        set_ready(4'b1111);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), route_val[i]);
            #1;
            check("route_in_ready", 32'(bus.In_Ready), 32'd1);
            step();
            check("route_valids", 32'({bus.Valid_D, bus.Valid_C, bus.Valid_B, bus.Valid_A}), 32'(1 << i));
        end
        check("route_out_a", 32'(bus.Out_A), 32'h11);
        check("route_out_b", 32'(bus.Out_B), 32'h22);
        check("route_out_c", 32'(bus.Out_C), 32'h33);
        check("route_out_d", 32'(bus.Out_D), 32'h44);
        drive(1'b0, 2'd0, 8'h00);
        step();
        check("route_drained", 32'({bus.Valid_D, bus.Valid_C, bus.Valid_B, bus.Valid_A}), 32'h0);
        check("route_keep_d", 32'(bus.Out_D), 32'h44);

        // Back-pressure on A; B still flows.
        set_ready(4'b1110);
        drive(1'b1, 2'd0, 8'h5A);
        step();
        check("bp_valid_a", 32'(bus.Valid_A), 32'd1);
        check("bp_out_a", 32'(bus.Out_A), 32'h5A);
        drive(1'b1, 2'd0, 8'h99);
        #1;
        check("bp_in_ready_a", 32'(bus.In_Ready), 32'd0);
        step();
        check("bp_hold_a", 32'(bus.Out_A), 32'h5A);
        drive(1'b1, 2'd1, 8'hB7);
        #1;
        check("bp_in_ready_b", 32'(bus.In_Ready), 32'd1);
        step();
        check("bp_valid_b", 32'(bus.Valid_B), 32'd1);
        check("bp_out_b", 32'(bus.Out_B), 32'hB7);
        check("bp_still_a", {bus.Out_A, 7'd0, bus.Valid_A}, {8'h5A, 8'h01});
        drive(1'b0, 2'd0, 8'h00);
        step();

        // Same-cycle drain and load of A.
        set_ready(4'b1111);
        drive(1'b1, 2'd0, 8'h01);
        step();
        check("dl_first", 32'(bus.Out_A), 32'h01);
        drive(1'b1, 2'd0, 8'h02);
        #1;
        check("dl_in_ready", 32'(bus.In_Ready), 32'd1);
        step();
        check("dl_valid_a", 32'(bus.Valid_A), 32'd1);
        check("dl_out_a", 32'(bus.Out_A), 32'h02);
        drive(1'b0, 2'd0, 8'h00);
        step();
        check("dl_empty_a", 32'(bus.Valid_A), 32'd0);

        // Asynchronous reset with B and C full.
        set_ready(4'b1001);
        drive(1'b1, 2'd1, 8'h3C);
        step();
        drive(1'b1, 2'd2, 8'hC3);
        step();
        drive(1'b0, 2'd0, 8'h00);
        check("ar_full_bc", 32'({bus.Valid_C, bus.Valid_B}), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valids", 32'({bus.Valid_D, bus.Valid_C, bus.Valid_B, bus.Valid_A}), 32'h0);
        check("ar_outs", {bus.Out_D, bus.Out_C, bus.Out_B, bus.Out_A}, 32'h0);
        #2;
        rst = 1'b0;
        step();

`ifdef DEMUX_STATS_EN
        // 65537 drains through D wrap the counter to 1.
        set_ready(4'b1111);
        drive(1'b1, 2'd3, 8'hD0);
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        check("stats_count_d", 32'(bus.Count_D), 32'd1);
        check("stats_count_abc", {bus.Count_C, bus.Count_B | bus.Count_A}, 32'h0);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
